// File: rtl/adc_spi_frame_ctrl_if.sv
// Bundle of pacing, control, SPI pin and sample signals between the ADC frame
// controller (master) and its environment (slave).
interface adc_spi_frame_ctrl_if #(
    parameter int DATA_BITS = 12
);
    logic                 sclk_tick;
    logic                 start;
    logic                 cont;
    logic                 miso;
    logic                 cs_n;
    logic                 spi_sck;
    logic [DATA_BITS-1:0] sample;
    logic                 sample_valid;
    logic                 frame_err;
    logic                 busy;
    logic [1:0]           state_dbg;

    // sample_valid is a one-cycle strobe with no ready: the consumer must take
    // sample in the cycle sample_valid is high; sample is held until the next one.
    modport master (
        input  sclk_tick, start, cont, miso,
        output cs_n, spi_sck, sample, sample_valid, frame_err, busy, state_dbg
    );

    modport slave (
        output sclk_tick, start, cont, miso,
        input  cs_n, spi_sck, sample, sample_valid, frame_err, busy, state_dbg
    );
endinterface

// File: rtl/adc_spi_frame_ctrl.sv
// Reads one 16-bit SPI frame from the 12-bit ADC per conversion, paced only by
// sclk_tick; single-shot via start, back-to-back while cont is high.
module adc_spi_frame_ctrl #(
    parameter int DATA_BITS   = 12,
    parameter int FRAME_BITS  = 16,
    parameter int QUIET_TICKS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    adc_spi_frame_ctrl_if.master bus
);
    localparam int CW = $clog2(FRAME_BITS + 1);
    localparam int QW = $clog2(QUIET_TICKS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic                  pending_q, pending_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [QW-1:0]         quiet_q, quiet_d;
    logic                  cs_n_q, cs_n_d;
    logic                  sck_q, sck_d;
    logic [DATA_BITS-1:0]  sample_q, sample_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;
    logic                  busy_q, busy_d;

    logic                  idle_go;
    logic                  last_capture;
    logic                  first_hold;
    logic                  hold_done;
    logic [FRAME_BITS-1:0] frame_word;

    assign idle_go      = pending_q | bus.cont;
    assign last_capture = !sck_q && (bit_cnt_q == CW'(FRAME_BITS - 1));
    assign frame_word   = {shift_q[FRAME_BITS-2:0], bus.miso};
    // cs_n is still low on the first HOLD tick; that tick already counts as quiet.
    assign first_hold   = !cs_n_q;
    assign hold_done    = first_hold ? (QUIET_TICKS == 1) : (quiet_q <= QW'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            quiet_q   <= '0;
            cs_n_q    <= 1'b1;
            sck_q     <= 1'b1;
            sample_q  <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            quiet_q   <= quiet_d;
            cs_n_q    <= cs_n_d;
            sck_q     <= sck_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.sclk_tick) begin
            case (state_q)
                IDLE:    if (idle_go) state_d = SETUP;
                SETUP:   state_d = SHIFT;
                SHIFT:   if (last_capture) state_d = HOLD;
                HOLD:    if (hold_done) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        pending_d = pending_q | bus.start;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        quiet_d   = quiet_q;
        cs_n_d    = cs_n_q;
        sck_d     = sck_q;
        sample_d  = sample_q;
        valid_d   = 1'b0;
        err_d     = err_q;
        busy_d    = busy_q;
        if (bus.sclk_tick) begin
            case (state_q)
                IDLE: begin
                    if (idle_go) begin
                        cs_n_d    = 1'b0;
                        busy_d    = 1'b1;
                        pending_d = 1'b0;
                    end
                end
                SETUP: begin
                    sck_d     = 1'b0;
                    bit_cnt_d = '0;
                end
                SHIFT: begin
                    if (!sck_q) begin
                        sck_d     = 1'b1;
                        shift_d   = frame_word;
                        bit_cnt_d = bit_cnt_q + CW'(1);
                        if (last_capture) begin
                            sample_d = frame_word[DATA_BITS-1:0];
                            err_d    = |frame_word[FRAME_BITS-1:DATA_BITS];
                            valid_d  = 1'b1;
                        end
                    end else begin
                        sck_d = 1'b0;
                    end
                end
                HOLD: begin
                    if (first_hold) begin
                        cs_n_d  = 1'b1;
                        quiet_d = QW'(QUIET_TICKS - 1);
                    end else begin
                        quiet_d = quiet_q - QW'(1);
                    end
                    if (hold_done) busy_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.cs_n         = cs_n_q;
    assign bus.spi_sck      = sck_q;
    assign bus.sample       = sample_q;
    assign bus.sample_valid = valid_q;
    assign bus.frame_err    = err_q;
    assign bus.busy         = busy_q;
    assign bus.state_dbg    = state_q;
endmodule

// File: tb/tb_adc_spi_frame_ctrl.sv
// Bench for adc_spi_frame_ctrl: ADC miso model, tick-indexed frame monitor,
// scoreboard against a word-level reference, directed table and random frames.
module tb_adc_spi_frame_ctrl;
    localparam int DB = 12;
    localparam int FB = 16;
    localparam int QT = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    adc_spi_frame_ctrl_if #(.DATA_BITS(DB)) bus ();

    adc_spi_frame_ctrl #(
        .DATA_BITS(DB), .FRAME_BITS(FB), .QUIET_TICKS(QT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: sample is the word modulo 2^DB, error if anything remains above it.
    function automatic logic [DB:0] ref_model(input logic [FB-1:0] w);
        int unsigned v;
        v = w;
        ref_model = {((v >> DB) != 0), DB'(v % (1 << DB))};
    endfunction

    // Tick generator: one-cycle pulses 2..4 clocks apart, numbered by tick_cnt.
    int tick_cnt = 0;
    initial begin
        int gap;
        gap = 0;
        bus.sclk_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (gap == 0) begin
                bus.sclk_tick = 1'b1;
                tick_cnt++;
                gap = $urandom_range(1, 3);
            end else begin
                bus.sclk_tick = 1'b0;
                gap--;
            end
        end
    end

    logic [FB-1:0] word_q[$];
    logic [DB:0]   exp_q[$];
    logic [FB-1:0] cur_word = '0;
    int            bidx = -1;

    // ADC model: next bit appears after each falling spi_sck while selected.
    initial begin
        bus.miso = 1'b0;
        forever begin
            @(negedge bus.spi_sck);
            if (!bus.cs_n && bidx >= 0) begin
                bus.miso = cur_word[bidx];
                bidx--;
            end
        end
    end

    int   frames = 0, valids = 0, frame_start = 0, rise_cnt = 0;
    int   idle_tick = 0, start_gap = 0;
    int   valid_ticks[$];
    logic p_cs = 1'b1, p_sck = 1'b1, p_busy = 1'b0, p_valid = 1'b0;

    initial begin
        logic [DB:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                p_cs = 1'b1; p_sck = 1'b1; p_busy = 1'b0; p_valid = 1'b0;
                rise_cnt = 0;
            end else begin
                if (p_cs && !bus.cs_n) begin
                    frame_start = tick_cnt;
                    start_gap   = tick_cnt - idle_tick;
                    frames++;
                    rise_cnt = 0;
                    bidx     = FB - 1;
                    if (word_q.size() != 0) cur_word = word_q.pop_front();
                    else if ($urandom_range(0, 1) == 1) cur_word = FB'($urandom_range(0, 65535));
                    else cur_word = FB'($urandom_range(0, (1 << DB) - 1));
                    exp_q.push_back(ref_model(cur_word));
                end
                if (!p_sck && bus.spi_sck && !bus.cs_n) rise_cnt++;
                if (bus.sample_valid) begin
                    valids++;
                    valid_ticks.push_back(tick_cnt);
                    chk("valid_tick", tick_cnt, frame_start + 32);
                    chk("valid_width", {31'd0, p_valid}, 0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL valid_unexpected: got strobe with sample 0x%0h, expected none", bus.sample);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_sample", bus.sample, e[DB-1:0]);
                        chk("sb_frame_err", bus.frame_err, e[DB]);
                    end
                end
                if (!p_cs && bus.cs_n) begin
                    chk("sck_rises", rise_cnt, FB);
                    chk("cs_rise_tick", tick_cnt, frame_start + 33);
                end
                if (p_busy && !bus.busy) begin
                    idle_tick = tick_cnt;
                    chk("idle_tick", tick_cnt, frame_start + 32 + QT);
                end
                p_cs = bus.cs_n; p_sck = bus.spi_sck; p_busy = bus.busy; p_valid = bus.sample_valid;
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
    endtask

    task automatic wait_ticks(input int n);
        int t;
        t = tick_cnt + n;
        while (tick_cnt < t) @(posedge clk);
    endtask

    task automatic wait_valids(input int target, input int max_cycles, input string name);
        int n;
        n = 0;
        while (valids < target && n < max_cycles) begin
            @(posedge clk);
            n++;
        end
        chk(name, valids, target);
    endtask

    task automatic wait_frames(input int target, input int max_cycles, input string name);
        int n;
        n = 0;
        while (frames < target && n < max_cycles) begin
            @(posedge clk);
            n++;
        end
        chk(name, frames, target);
    endtask

    task automatic wait_idle(input int max_cycles, input string name);
        int n;
        n = 0;
        while (bus.busy && n < max_cycles) begin
            @(posedge clk);
            n++;
        end
        chk(name, {31'd0, bus.busy}, 0);
    endtask

    typedef struct {
        logic [FB-1:0] word;
        logic [DB-1:0] smp;
        logic          err;
    } vec_t;
    vec_t tbl[6];

    initial begin
        int f0, v0, n, mode;
        #900000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, v0, n, mode;
        tbl[0] = '{16'h0A5C, 12'hA5C, 1'b0};
        tbl[1] = '{16'h8FFF, 12'hFFF, 1'b1};
        tbl[2] = '{16'h0000, 12'h000, 1'b0};
        tbl[3] = '{16'h0FFF, 12'hFFF, 1'b0};
        tbl[4] = '{16'h1000, 12'h000, 1'b1};
        tbl[5] = '{16'h4123, 12'h123, 1'b1};

        bus.start = 1'b0;
        bus.cont  = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_cs_n", {31'd0, bus.cs_n}, 1);
        chk("rst_sck", {31'd0, bus.spi_sck}, 1);
        chk("rst_sample", bus.sample, 0);
        chk("rst_valid", {31'd0, bus.sample_valid}, 0);
        chk("rst_err", {31'd0, bus.frame_err}, 0);
        chk("rst_busy", {31'd0, bus.busy}, 0);
        chk("rst_state", bus.state_dbg, 0);
        rst = 1'b1;

        wait_ticks(100);
        chk("idle_frames", frames, 0);
        chk("idle_valids", valids, 0);
        chk("idle_cs_n", {31'd0, bus.cs_n}, 1);
        chk("idle_sck", {31'd0, bus.spi_sck}, 1);
        chk("idle_busy", {31'd0, bus.busy}, 0);

        for (int i = 0; i < 6; i++) begin
            word_q.push_back(tbl[i].word);
            v0 = valids;
            pulse_start();
            wait_valids(v0 + 1, 600, "tbl_valid");
            chk("tbl_sample", bus.sample, tbl[i].smp);
            chk("tbl_frame_err", {31'd0, bus.frame_err}, tbl[i].err);
            wait_idle(200, "tbl_idle");
        end

        // Continuous: drop cont once the third frame has started.
        for (int i = 0; i < 3; i++) word_q.push_back(16'h0100 * (i + 1) + 16'h0011);
        f0 = frames; v0 = valids; n = valid_ticks.size();
        @(posedge clk); #1 bus.cont = 1'b1;
        wait_frames(f0 + 3, 2000, "cont_frames_started");
        #1 bus.cont = 1'b0;
        wait_valids(v0 + 3, 600, "cont_valids");
        wait_idle(200, "cont_idle");
        wait_ticks(60);
        chk("cont_frames", frames, f0 + 3);
        chk("cont_spacing_1", valid_ticks[n+1] - valid_ticks[n], 33 + QT);
        chk("cont_spacing_2", valid_ticks[n+2] - valid_ticks[n+1], 33 + QT);
        chk("cont_end_busy", {31'd0, bus.busy}, 0);
        chk("cont_end_cs_n", {31'd0, bus.cs_n}, 1);

        // Two start pulses mid-frame queue exactly one more frame.
        f0 = frames; v0 = valids;
        pulse_start();
        wait_frames(f0 + 1, 600, "dbl_first_start");
        wait_ticks(8);
        pulse_start();
        wait_ticks(6);
        pulse_start();
        wait_valids(v0 + 2, 1200, "dbl_valids");
        wait_idle(200, "dbl_idle");
        wait_ticks(80);
        chk("dbl_frames", frames, f0 + 2);
        chk("dbl_start_gap", start_gap, 1);

        // Asynchronous reset at T10 of a frame.
        f0 = frames; v0 = valids;
        pulse_start();
        wait_frames(f0 + 1, 600, "rst_frame_start");
        while (tick_cnt < frame_start + 10) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_cs_n", {31'd0, bus.cs_n}, 1);
        chk("midrst_sck", {31'd0, bus.spi_sck}, 1);
        chk("midrst_sample", bus.sample, 0);
        chk("midrst_valid", {31'd0, bus.sample_valid}, 0);
        chk("midrst_busy", {31'd0, bus.busy}, 0);
        repeat (4) @(posedge clk);
        exp_q.delete();
        #1 rst = 1'b1;
        wait_ticks(5);
        chk("midrst_no_valid", valids, v0);
        word_q.push_back(16'h0C3A);
        pulse_start();
        wait_valids(v0 + 1, 600, "post_rst_valid");
        chk("post_rst_sample", bus.sample, 12'hC3A);
        chk("post_rst_err", {31'd0, bus.frame_err}, 0);
        wait_idle(200, "post_rst_idle");

        // Random frames: single start, start plus one queued, or a one-frame cont burst.
        for (int i = 0; i < 25; i++) begin
            f0 = frames; v0 = valids;
            mode = $urandom_range(0, 2);
            wait_ticks($urandom_range(0, 5));
            if (mode == 2) begin
                @(posedge clk); #1 bus.cont = 1'b1;
                wait_frames(f0 + 1, 600, "rnd_cont_start");
                #1 bus.cont = 1'b0;
                n = 1;
            end else begin
                pulse_start();
                n = 1;
                if (mode == 1) begin
                    wait_frames(f0 + 1, 600, "rnd_first_start");
                    wait_ticks($urandom_range(1, 30));
                    pulse_start();
                    n = 2;
                end
            end
            wait_valids(v0 + n, 1200, "rnd_valids");
            wait_idle(200, "rnd_idle");
            wait_ticks(3);
            chk("rnd_frames", frames, f0 + n);
        end

        chk("sb_leftover", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
